// File: rtl/plic_gateway.sv
// Per-source interrupt gateway in front of the PLIC core: synchronizes raw
// lines and keeps at most one outstanding request per source until completion.
module plic_gateway #(
  parameter int NSOURCES    = 32,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_WIDTH   = 4,
  localparam int IDW        = $clog2(NSOURCES)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NSOURCES-1:0] irq_raw_i,
  input  logic [NSOURCES-1:0] edge_mode_i,
  input  logic [NSOURCES-1:0] gate_en_i,
  output logic [NSOURCES-1:0] req_o,
  output logic [NSOURCES-1:0] in_service_o,
  input  logic                claim_valid_i,
  input  logic [IDW-1:0]      claim_id_i,
  input  logic                complete_valid_i,
  input  logic [IDW-1:0]      complete_id_i,
  output logic [NSOURCES-1:0] overflow_o,
  input  logic                overflow_clr_i
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_INSVC = 2'd2
  } state_e;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [NSOURCES-1:0]  sync_q [SYNC_STAGES];
  logic [NSOURCES-1:0]  s_prev_q;
  logic [NSOURCES-1:0]  s;
  logic [NSOURCES-1:0]  rise;

  state_e               state_q [NSOURCES];
  state_e               state_d [NSOURCES];
  logic [CNT_WIDTH-1:0] cnt_q   [NSOURCES];
  logic [CNT_WIDTH-1:0] cnt_d   [NSOURCES];

  logic [NSOURCES-1:0]  ovf_q, ovf_d;
  logic [NSOURCES-1:0]  req_q, req_d;
  logic [NSOURCES-1:0]  insvc_q, insvc_d;

  logic [NSOURCES-1:0]  inc;
  logic [NSOURCES-1:0]  dec;
  logic [NSOURCES-1:0]  cred;

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_prev_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q & ~{NSOURCES{overflow_clr_i}};
    inc     = edge_mode_i & gate_en_i & rise;
    dec     = '0;
    cred    = '0;
    req_d   = '0;
    insvc_d = '0;

    for (int i = 0; i < NSOURCES; i++) begin
      case (state_q[i])
        ST_IDLE: begin
          if (gate_en_i[i] &&
              (edge_mode_i[i] ? (cnt_q[i] != '0) : s[i])) begin
            state_d[i] = ST_REQ;
            dec[i]     = edge_mode_i[i];
          end
        end
        ST_REQ: begin
          // A claim already seen by the core wins over a same-cycle disable.
          if (claim_valid_i && claim_id_i == IDW'(i)) begin
            state_d[i] = ST_INSVC;
          end else if (!gate_en_i[i]) begin
            state_d[i] = ST_IDLE;
            cred[i]    = edge_mode_i[i];
          end
        end
        ST_INSVC: begin
          if (complete_valid_i && complete_id_i == IDW'(i)) begin
            state_d[i] = ST_IDLE;
          end
        end
        default: state_d[i] = ST_IDLE;
      endcase

      if (!edge_mode_i[i]) begin
        cnt_d[i] = '0;
      end else if ((inc[i] || cred[i]) && !dec[i]) begin
        if (cnt_q[i] != CNT_MAX) begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end else if (inc[i]) begin
          ovf_d[i] = 1'b1;
        end
      end else if (dec[i] && !(inc[i] || cred[i])) begin
        cnt_d[i] = cnt_q[i] - 1'b1;
      end
    end

    state_d[0] = ST_IDLE;
    cnt_d[0]   = '0;
    ovf_d[0]   = 1'b0;

    for (int i = 0; i < NSOURCES; i++) begin
      req_d[i]   = (state_d[i] == ST_REQ);
      insvc_d[i] = (state_d[i] == ST_INSVC);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
      for (int i = 0; i < NSOURCES; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
      end
      s_prev_q <= '0;
      ovf_q    <= '0;
      req_q    <= '0;
      insvc_q  <= '0;
    end else begin
      sync_q[0] <= irq_raw_i;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
      s_prev_q <= s;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      req_q    <= req_d;
      insvc_q  <= insvc_d;
    end
  end

  assign req_o        = req_q;
  assign in_service_o = insvc_q;
  assign overflow_o   = ovf_q;

endmodule

// File: tb/tb_plic_gateway.sv
// Bench for plic_gateway: vector table, directed corner sequences and
// randomized traffic against a cycle-level reference model.
module tb_plic_gateway;

  localparam int NS   = 32;
  localparam int SS   = 2;
  localparam int CW   = 4;
  localparam int IDW  = 5;
  localparam int CMAX = (1 << CW) - 1;

  logic           clk = 1'b0;
  logic           rst;
  logic [NS-1:0]  raw, edge_m, gate;
  logic           cv, pv, clr;
  logic [IDW-1:0] cid, pid;
  logic [NS-1:0]  req_o, in_service_o, overflow_o;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  plic_gateway #(
    .NSOURCES(NS), .SYNC_STAGES(SS), .CNT_WIDTH(CW)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .irq_raw_i(raw), .edge_mode_i(edge_m), .gate_en_i(gate),
    .req_o(req_o), .in_service_o(in_service_o),
    .claim_valid_i(cv), .claim_id_i(cid),
    .complete_valid_i(pv), .complete_id_i(pid),
    .overflow_o(overflow_o), .overflow_clr_i(clr)
  );

  // Reference model: raw-sample history plus per-source status and count.
  logic [NS-1:0] hist [$];
  logic [NS-1:0] m_req, m_svc, m_ovf;
  int            m_cnt [NS];

  task automatic chk(input string name, input logic [NS-1:0] act,
                     input logic [NS-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    repeat (SS + 1) hist.push_back('0);
    m_req = '0;
    m_svc = '0;
    m_ovf = '0;
    for (int i = 0; i < NS; i++) m_cnt[i] = 0;
  endtask

  task automatic model_step();
    logic [NS-1:0] s, sp, nreq, nsvc, novf;
    int total, took, credit;
    bit rise;
    if (rst) begin
      model_reset();
      return;
    end
    s    = hist[hist.size() - SS];
    sp   = hist[hist.size() - SS - 1];
    nreq = m_req;
    nsvc = m_svc;
    novf = m_ovf & ~{NS{clr}};
    for (int i = 1; i < NS; i++) begin
      rise   = edge_m[i] && gate[i] && s[i] && !sp[i];
      took   = 0;
      credit = 0;
      if (m_svc[i]) begin
        if (pv && int'(pid) == i) nsvc[i] = 1'b0;
      end else if (m_req[i]) begin
        if (cv && int'(cid) == i) begin
          nreq[i] = 1'b0;
          nsvc[i] = 1'b1;
        end else if (!gate[i]) begin
          nreq[i] = 1'b0;
          credit  = edge_m[i] ? 1 : 0;
        end
      end else if (gate[i] &&
                   (edge_m[i] ? m_cnt[i] > 0 : s[i] == 1'b1)) begin
        nreq[i] = 1'b1;
        took    = edge_m[i] ? 1 : 0;
      end
      total = m_cnt[i] + int'(rise) + credit - took;
      if (total > CMAX) begin
        total = CMAX;
        if (rise) novf[i] = 1'b1;
      end
      if (!edge_m[i]) total = 0;
      m_cnt[i] = total;
    end
    m_req = nreq;
    m_svc = nsvc;
    m_ovf = novf;
    hist.push_back(raw);
    void'(hist.pop_front());
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    chk("model_req", req_o, m_req);
    chk("model_svc", in_service_o, m_svc);
    chk("model_ovf", overflow_o, m_ovf);
    cv  = 1'b0;
    pv  = 1'b0;
    clr = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_req(input int idx, input int lim, output bit seen);
    seen = 1'b0;
    for (int t = 0; t < lim && !seen; t++) begin
      if (req_o[idx]) seen = 1'b1;
      else tick();
    end
    if (!seen && req_o[idx]) seen = 1'b1;
  endtask

  task automatic serve(input int idx);
    cv  = 1'b1;
    cid = IDW'(idx);
    tick();
    pv  = 1'b1;
    pid = IDW'(idx);
    tick();
  endtask

  task automatic drain(input int idx, input int maxn, output int n);
    bit seen;
    n = 0;
    for (int r = 0; r < maxn; r++) begin
      wait_req(idx, 12, seen);
      if (!seen) break;
      n++;
      serve(idx);
    end
  endtask

  function automatic int pick(input logic [NS-1:0] v);
    int o;
    o = $urandom_range(0, NS - 1);
    for (int k = 0; k < NS; k++) begin
      if (v[(o + k) % NS]) return (o + k) % NS;
    end
    return o;
  endfunction

  typedef struct {
    bit            cv;
    int            cid;
    bit            pv;
    int            pid;
    logic [NS-1:0] req;
    logic [NS-1:0] svc;
  } vec_t;

  vec_t tbl [12];

  initial begin
    #5ms;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    bit seen;
    int n;

    tbl = '{
      '{0, 0, 0, 0, 32'h00, 32'h00},
      '{0, 0, 0, 0, 32'h00, 32'h00},
      '{0, 0, 0, 0, 32'h70, 32'h00},
      '{1, 5, 0, 0, 32'h50, 32'h20},
      '{1, 6, 0, 0, 32'h10, 32'h60},
      '{1, 9, 0, 0, 32'h10, 32'h60},
      '{1, 4, 1, 6, 32'h00, 32'h30},
      '{0, 0, 0, 0, 32'h40, 32'h30},
      '{0, 0, 1, 5, 32'h40, 32'h10},
      '{0, 0, 0, 0, 32'h60, 32'h10},
      '{0, 0, 1, 6, 32'h60, 32'h10},
      '{1, 0, 0, 0, 32'h60, 32'h10}
    };

    rst = 1'b1; raw = '0; edge_m = '0; gate = '0;
    cv = 1'b0; pv = 1'b0; clr = 1'b0; cid = '0; pid = '0;
    model_reset();
    tick();
    tick();
    rst = 1'b0;
    chk("reset_req", req_o, '0);
    chk("reset_svc", in_service_o, '0);
    chk("reset_ovf", overflow_o, '0);

    // Level sources 4,5,6 plus reserved source 0, all held high.
    raw  = 32'h71;
    gate = 32'h71;
    for (int r = 0; r < 12; r++) begin
      cv  = tbl[r].cv;
      cid = IDW'(tbl[r].cid);
      pv  = tbl[r].pv;
      pid = IDW'(tbl[r].pid);
      tick();
      chk($sformatf("tbl_req_%0d", r), req_o, tbl[r].req);
      chk($sformatf("tbl_svc_%0d", r), in_service_o, tbl[r].svc);
      chk($sformatf("tbl_ovf_%0d", r), overflow_o, '0);
    end

    // Three edges on source 3 before any claim: three requests total.
    raw = '0; gate = '0;
    do_reset();
    edge_m = 32'd1 << 3;
    gate   = 32'd1 << 3;
    repeat (3) begin
      raw[3] = 1'b1;
      repeat (4) tick();
      raw[3] = 1'b0;
      repeat (4) tick();
    end
    drain(3, 6, n);
    chki("edge3_nreq", n, 3);
    chki("edge3_quiet", int'(req_o[3]), 0);

    // Disable while requesting with an empty count re-credits one edge.
    do_reset();
    raw[3] = 1'b1;
    tick(); tick();
    raw[3] = 1'b0;
    wait_req(3, 10, seen);
    chki("gd_req", int'(seen), 1);
    gate = '0;
    tick();
    chki("gd_drop", int'(req_o[3]), 0);
    gate = 32'd1 << 3;
    tick();
    chki("gd_reen", int'(req_o[3]), 1);
    serve(3);
    wait_req(3, 8, seen);
    chki("gd_none", int'(seen), 0);

    // Seventeen edges on source 7 saturate the count and lose one.
    do_reset();
    edge_m = 32'd1 << 7;
    gate   = 32'd1 << 7;
    repeat (17) begin
      raw[7] = 1'b1; tick(); tick();
      raw[7] = 1'b0; tick(); tick();
    end
    repeat (4) tick();
    chki("e7_req", int'(req_o[7]), 1);
    chki("e7_ovf", int'(overflow_o[7]), 1);
    clr = 1'b1;
    tick();
    chki("e7_clr", int'(overflow_o[7]), 0);
    raw[7] = 1'b1; tick(); tick();
    raw[7] = 1'b0; repeat (4) tick();
    chki("e7_reovf", int'(overflow_o[7]), 1);
    drain(7, 20, n);
    chki("e7_drain", n, 16);

    // Reset with sources requesting, in service and overflowed.
    raw  = 32'h7;
    gate = gate | 32'h7;
    repeat (4) tick();
    cv = 1'b1; cid = IDW'(2);
    tick();
    chki("rst_pre_svc", int'(in_service_o[2]), 1);
    chki("rst_pre_req", int'(req_o[1]), 1);
    chki("rst_pre_ovf", int'(overflow_o[7]), 1);
    do_reset();
    chk("rst_req", req_o, '0);
    chk("rst_svc", in_service_o, '0);
    chk("rst_ovf", overflow_o, '0);
    repeat (5) tick();
    chki("src0_never", int'(req_o[0]), 0);

    // Randomized traffic against the model.
    raw = '0;
    for (int seg = 0; seg < 6; seg++) begin
      int cl_pct;
      edge_m = $urandom();
      gate   = $urandom() | $urandom();
      cl_pct = 10 + 20 * seg;
      for (int c = 0; c < 400; c++) begin
        raw = raw ^ ($urandom() & $urandom() & $urandom());
        if ($urandom_range(0, 15) == 0)
          gate[$urandom_range(0, NS - 1)] ^= 1'b1;
        if ($urandom_range(0, 99) < cl_pct) begin
          cv  = 1'b1;
          cid = IDW'(pick(m_req));
        end
        if ($urandom_range(0, 99) < cl_pct) begin
          pv  = 1'b1;
          pid = IDW'(pick(m_svc));
        end
        if ($urandom_range(0, 31) == 0) clr = 1'b1;
        if ($urandom_range(0, 499) == 0) rst = 1'b1;
        tick();
        rst = 1'b0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
